instr_mem: RTL and testbench



---
 rtl/scc_pkg.sv | 24 ++
 rtl/instr_mem_if.sv | 25 ++
 rtl/instr_mem_array.sv | 28 ++
 rtl/instr_mem.sv | 141 ++++++++++++++
 tb/tb_instr_mem.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/scc_pkg.sv
// rtl/scc_pkg.sv - shared types and constants for the SCC instruction memory
package scc_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam logic [31:0] SCC_NOP_WORD = 32'hC800_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_e;

  // Left-justify the n assembled bytes held in the low end of w, zeroing the rest.
  function automatic logic [INSTR_W-1:0] zero_fill(input logic [INSTR_W-1:0] w,
                                                   input logic [1:0] n);
    case (n)
      2'd1:    return {w[7:0], 24'h0};
      2'd2:    return {w[15:0], 16'h0};
      2'd3:    return {w[23:0], 8'h0};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/instr_mem_if.sv
// rtl/instr_mem_if.sv - fetch, loader and status signals of the instruction memory
interface instr_mem_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] instruction;
  logic        fetch_fault;
  logic        load_start;
  logic [7:0]  load_byte;
  logic        load_byte_valid;
  logic        load_end;
  logic        load_busy;
  logic        mem_ready;
  logic        load_overflow;

  modport master (
    output fetch_req, fetch_addr, load_start, load_byte, load_byte_valid, load_end,
    input  fetch_valid, instruction, fetch_fault, load_busy, mem_ready, load_overflow
  );

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_byte, load_byte_valid, load_end,
    output fetch_valid, instruction, fetch_fault, load_busy, mem_ready, load_overflow
  );
endinterface

// File: rtl/instr_mem_array.sv
// rtl/instr_mem_array.sv - 1R1W word RAM with registered read, read-before-write
module instr_mem_array
  import scc_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               re_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rdata_q;

  // Same-edge read of a word being written returns the old contents.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - instruction memory responder with byte-serial image loader
module instr_mem
  import scc_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [31:0] NOP_WORD = SCC_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  instr_mem_if.slave  bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);

  state_e             state_q;
  logic [AW:0]        ptr_q, ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [INSTR_W-1:0] asm_q, asm_d;
  logic               ovf_q, ovf_d;
  logic               word_done, flush;

  logic               wr_en_q;
  logic [AW-1:0]      wr_addr_q;
  logic [INSTR_W-1:0] wr_data_q;

  logic               fetch_valid_q, fetch_fault_q, use_ram_q;
  logic               addr_fault;
  logic [INSTR_W-1:0] ram_rdata;

  assign addr_fault = (|bus.fetch_addr[1:0]) || (|bus.fetch_addr[31:AW+2]);

  // Byte assembler step: effect of the current byte, then whether load_end must flush a partial word.
  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    ovf_d     = ovf_q;
    word_done = 1'b0;
    if (bus.load_byte_valid) begin
      if (ptr_q == PTR_FULL) begin
        ovf_d = 1'b1;
      end else begin
        asm_d = {asm_q[23:0], bus.load_byte};
        if (cnt_q == 2'd3) begin
          word_done = 1'b1;
          cnt_d     = 2'd0;
          ptr_d     = ptr_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
    end
    flush = bus.load_end && (cnt_d != 2'd0) && (ptr_d != PTR_FULL);
  end

  // Load FSM: state, pointer, assembly register, overflow flag and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      asm_q     <= '0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (bus.load_start) begin
        state_q <= LOADING;
        ptr_q   <= '0;
        cnt_q   <= '0;
        asm_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        case (state_q)
          LOADING: begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            asm_q <= asm_d;
            ovf_q <= ovf_d;
            if (word_done) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= ptr_q[AW-1:0];
              wr_data_q <= asm_d;
            end else if (flush) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= ptr_d[AW-1:0];
              wr_data_q <= zero_fill(asm_d, cnt_d);
            end
            if (bus.load_end) begin
              state_q <= READY;
              cnt_q   <= '0;
            end
          end
          IDLE, READY: state_q <= state_q;
          default:     state_q <= IDLE;
        endcase
      end
    end
  end

  // Fetch response: one strobe per request; serve from RAM only in READY with a legal address.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      use_ram_q     <= 1'b0;
    end else begin
      fetch_valid_q <= bus.fetch_req;
      if (bus.fetch_req) begin
        use_ram_q     <= (state_q == READY) && !addr_fault;
        fetch_fault_q <= (state_q == READY) && addr_fault;
      end else begin
        fetch_fault_q <= 1'b0;
      end
    end
  end

  instr_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .re_i    (bus.fetch_req),
    .raddr_i (bus.fetch_addr[AW+1:2]),
    .rdata_o (ram_rdata),
    .we_i    (wr_en_q),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_data_q)
  );

  assign bus.fetch_valid   = fetch_valid_q;
  assign bus.fetch_fault   = fetch_fault_q;
  assign bus.instruction   = use_ram_q ? ram_rdata : NOP_WORD;
  assign bus.load_busy     = (state_q == LOADING);
  assign bus.mem_ready     = (state_q == READY);
  assign bus.load_overflow = ovf_q;

endmodule

// File: tb/tb_instr_mem.sv
// tb/tb_instr_mem.sv - scoreboard testbench for instr_mem
module tb_instr_mem;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] NOP   = 32'hC800_0000;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  instr_mem_if bus();

  instr_mem #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef);
    exp_t e;
    e.instr = ei;
    e.fault = ef;
    sb_q.push_back(e);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    tick();
    bus.fetch_req  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.load_byte_valid = 1'b1;
    bus.load_byte       = b;
    tick();
    bus.load_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic pulse_end();
    bus.load_end = 1'b1;
    tick();
    bus.load_end = 1'b0;
  endtask

  // Monitor: every response strobe is matched against the oldest expected response.
  always @(negedge clk) begin
    if (!reset && bus.fetch_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch_valid: got instruction %h with empty scoreboard", bus.instruction);
      end else begin
        mon_e = sb_q.pop_front();
        check("fetch_instruction", bus.instruction, mon_e.instr);
        check("fetch_fault", 32'(bus.fetch_fault), 32'(mon_e.fault));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d responses outstanding", sb_q.size());
    $fatal(1);
  end

  initial begin
    reset               = 1'b1;
    bus.fetch_req       = 1'b0;
    bus.fetch_addr      = '0;
    bus.load_start      = 1'b0;
    bus.load_byte       = '0;
    bus.load_byte_valid = 1'b0;
    bus.load_end        = 1'b0;
    tick();
    tick();
    check("rst_fetch_valid", 32'(bus.fetch_valid), 0);
    check("rst_instruction", bus.instruction, NOP);
    check("rst_fetch_fault", 32'(bus.fetch_fault), 0);
    check("rst_load_busy", 32'(bus.load_busy), 0);
    check("rst_mem_ready", 32'(bus.mem_ready), 0);
    check("rst_load_overflow", 32'(bus.load_overflow), 0);
    reset = 1'b0;

    fetch(32'h0, NOP, 1'b0);
    tick();
    check("idle_mem_ready", 32'(bus.mem_ready), 0);

    pulse_start();
    check("loading_busy", 32'(bus.load_busy), 1);
    send_word(32'h1234_5678);
    send_byte(8'hAA);
    bus.load_end   = 1'b1;
    fetch(32'h0, NOP, 1'b0);
    bus.load_end   = 1'b0;
    check("ready_after_end", 32'(bus.mem_ready), 1);
    check("busy_after_end", 32'(bus.load_busy), 0);
    tick();
    fetch(32'h0, 32'h1234_5678, 1'b0);
    fetch(32'h4, 32'hAA00_0000, 1'b0);
    fetch(32'h6, NOP, 1'b1);
    fetch(32'(4 * DEPTH), NOP, 1'b1);
    fetch(32'h8000_0000, NOP, 1'b1);

    send_word(32'h5555_5555);
    tick();
    fetch(32'h0, 32'h1234_5678, 1'b0);
    fetch(32'h4, 32'hAA00_0000, 1'b0);

    pulse_start();
    check("ovf_clear_on_start", 32'(bus.load_overflow), 0);
    for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'(i));
    check("no_ovf_at_full", 32'(bus.load_overflow), 0);
    send_byte(8'hFF);
    check("ovf_set", 32'(bus.load_overflow), 1);
    pulse_end();
    tick();
    fetch(32'(4 * (DEPTH - 1)), 32'h3C3D_3E3F, 1'b0);
    fetch(32'h0, 32'h0001_0203, 1'b0);
    check("ovf_sticky_ready", 32'(bus.load_overflow), 1);
    pulse_start();
    check("ovf_cleared_restart", 32'(bus.load_overflow), 0);

    send_byte(8'h99);
    send_byte(8'h99);
    send_byte(8'h99);
    pulse_start();
    send_word(32'hDEAD_BEEF);
    pulse_end();
    tick();
    fetch(32'h0, 32'hDEAD_BEEF, 1'b0);
    fetch(32'h4, 32'h0405_0607, 1'b0);

    pulse_start();
    send_byte(8'h77);
    send_byte(8'h66);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midload_rst_busy", 32'(bus.load_busy), 0);
    check("midload_rst_ready", 32'(bus.mem_ready), 0);
    check("midload_rst_ovf", 32'(bus.load_overflow), 0);
    fetch(32'h0, NOP, 1'b0);
    fetch(32'h6, NOP, 1'b0);
    pulse_start();
    fetch(32'h0, NOP, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    bus.load_byte_valid = 1'b1;
    bus.load_byte       = 8'h33;
    bus.load_end        = 1'b1;
    tick();
    bus.load_byte_valid = 1'b0;
    bus.load_end        = 1'b0;
    tick();
    fetch(32'h0, 32'h1122_3300, 1'b0);
    fetch(32'h4, 32'h0405_0607, 1'b0);

    tick();
    tick();
    tick();
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
